icache_refill_ctrl: RTL and testbench

ICACHE_REFILL_CTRL -- requirements
Module: icache_refill_ctrl

---
 rtl/icache_refill_ctrl.sv | 139 +++++++++++++
 tb/tb_icache_refill_ctrl.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/icache_refill_ctrl.sv
// Instruction-cache line refill controller: burst-reads one line on a miss and owns fence.i invalidation.
// Optional refill counter output o_miss_count is built when ICACHE_MISS_CNT_EN is defined.
//   state  | meaning
//   IDLE   | serving hits; starts refills and issues pending invalidates
//   REQ    | burst request presented, waiting for i_mem_ready
//   WAIT   | collecting read beats into the line buffer
//   FILL   | one-cycle cache write of the assembled line
module icache_refill_ctrl #(
    parameter int BLOCK_WIDTH = 256,
    parameter int WORD_SIZE   = 32,
    parameter int ADDR_WIDTH  = 32
) (
    input  logic                   clk,
    input  logic                   arst,
    input  logic                   i_fetch_req,
    input  logic [ADDR_WIDTH-1:0]  i_instr_addr,
    input  logic                   i_hit,
    input  logic                   i_flush,
    output logic                   o_mem_req,
    output logic [ADDR_WIDTH-1:0]  o_mem_addr,
    input  logic                   i_mem_ready,
    input  logic                   i_mem_rvalid,
    input  logic [WORD_SIZE-1:0]   i_mem_rdata,
    output logic                   o_cache_we,
    output logic [BLOCK_WIDTH-1:0] o_line,
    output logic                   o_invalidate,
    output logic                   o_stall
`ifdef ICACHE_MISS_CNT_EN
    ,
    output logic [31:0]            o_miss_count
`endif
);

    localparam int BEATS    = BLOCK_WIDTH / WORD_SIZE;
    localparam int CNT_W    = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam int LINE_OFF = $clog2(BLOCK_WIDTH / 8);
    localparam logic [ADDR_WIDTH-1:0] LINE_MASK = {ADDR_WIDTH{1'b1}} << LINE_OFF;
    localparam logic [CNT_W-1:0]      LAST_BEAT = CNT_W'(BEATS - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_REQ,
        S_WAIT,
        S_FILL
    } state_t;

    state_t                 r_state;
    logic [CNT_W-1:0]       r_beat;
    logic                   r_flush_pend;
    logic                   r_mem_req;
    logic [ADDR_WIDTH-1:0]  r_mem_addr;
    logic                   r_cache_we;
    logic [BLOCK_WIDTH-1:0] r_line;

    logic w_idle;
    logic w_miss;
    logic w_start;

    assign w_idle  = (r_state == S_IDLE);
    // Misaligned fetches belong to the exception path, so they never count as a miss here.
    assign w_miss  = i_fetch_req & ~i_hit & (i_instr_addr[1:0] == 2'b00);
    // A flush arriving with the miss wins; the refill starts only after the invalidate cycle.
    assign w_start = w_idle & w_miss & ~r_flush_pend & ~i_flush;

    always_ff @(posedge clk) begin
        if (arst) begin
            r_state      <= S_IDLE;
            r_beat       <= '0;
            r_flush_pend <= 1'b0;
            r_mem_req    <= 1'b0;
            r_mem_addr   <= '0;
            r_cache_we   <= 1'b0;
            r_line       <= '0;
        end else begin
            if (i_flush) begin
                r_flush_pend <= 1'b1;
            end else if (w_idle) begin
                r_flush_pend <= 1'b0;
            end

            case (r_state)
                S_IDLE: begin
                    if (w_start) begin
                        r_mem_addr <= i_instr_addr & LINE_MASK;
                        r_mem_req  <= 1'b1;
                        r_state    <= S_REQ;
                    end
                end
                S_REQ: begin
                    if (i_mem_ready) begin
                        r_mem_req <= 1'b0;
                        r_beat    <= '0;
                        r_state   <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (i_mem_rvalid) begin
                        r_line[int'(r_beat)*WORD_SIZE +: WORD_SIZE] <= i_mem_rdata;
                        if (r_beat == LAST_BEAT) begin
                            r_cache_we <= 1'b1;
                            r_state    <= S_FILL;
                        end else begin
                            r_beat <= r_beat + CNT_W'(1);
                        end
                    end
                end
                S_FILL: begin
                    r_cache_we <= 1'b0;
                    r_state    <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

`ifdef ICACHE_MISS_CNT_EN
    logic [31:0] r_miss_count;

    always_ff @(posedge clk) begin
        if (arst) begin
            r_miss_count <= '0;
        end else if (w_start) begin
            r_miss_count <= r_miss_count + 32'd1;
        end
    end

    assign o_miss_count = r_miss_count;
`endif

    assign o_mem_req    = r_mem_req;
    assign o_mem_addr   = r_mem_addr;
    assign o_cache_we   = r_cache_we;
    assign o_line       = r_line;
    assign o_invalidate = w_idle & r_flush_pend;
    assign o_stall      = ~w_idle | r_flush_pend | (w_idle & w_miss);

endmodule

// File: tb/tb_icache_refill_ctrl.sv
// Self-checking bench for icache_refill_ctrl: directed scenarios with literal expectations plus
// randomized traffic, all compared every cycle against a transaction-level model of the refill.
module tb_icache_refill_ctrl;

    logic         clk = 1'b0;
    logic         arst;
    logic         i_fetch_req;
    logic [31:0]  i_instr_addr;
    logic         i_hit;
    logic         i_flush;
    logic         o_mem_req;
    logic [31:0]  o_mem_addr;
    logic         i_mem_ready;
    logic         i_mem_rvalid;
    logic [31:0]  i_mem_rdata;
    logic         o_cache_we;
    logic [255:0] o_line;
    logic         o_invalidate;
    logic         o_stall;
`ifdef ICACHE_MISS_CNT_EN
    logic [31:0]  o_miss_count;
`endif

    icache_refill_ctrl #(
        .BLOCK_WIDTH(256),
        .WORD_SIZE  (32),
        .ADDR_WIDTH (32)
    ) dut (
        .clk         (clk),
        .arst        (arst),
        .i_fetch_req (i_fetch_req),
        .i_instr_addr(i_instr_addr),
        .i_hit       (i_hit),
        .i_flush     (i_flush),
        .o_mem_req   (o_mem_req),
        .o_mem_addr  (o_mem_addr),
        .i_mem_ready (i_mem_ready),
        .i_mem_rvalid(i_mem_rvalid),
        .i_mem_rdata (i_mem_rdata),
        .o_cache_we  (o_cache_we),
        .o_line      (o_line),
        .o_invalidate(o_invalidate),
        .o_stall     (o_stall)
`ifdef ICACHE_MISS_CNT_EN
        ,
        .o_miss_count(o_miss_count)
`endif
    );

    always #5 clk = ~clk;

    int n_total = 0;
    int n_pass  = 0;

    // Transaction-level model: a refill is "busy" from miss capture until its write cycle ends.
    bit          m_busy;
    bit          m_issued;
    int          m_nbeats;
    bit          m_pend;
    logic [31:0] m_base;
    logic [31:0] m_words [8];
    logic [31:0] m_cnt;

    logic         obs_req, obs_we, obs_inv, obs_stall;
    logic [31:0]  obs_addr;
    logic [255:0] obs_line;

    task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic model_reset();
        m_busy   = 0;
        m_issued = 0;
        m_nbeats = 0;
        m_pend   = 0;
        m_base   = '0;
        m_cnt    = '0;
        for (int i = 0; i < 8; i++) m_words[i] = '0;
    endtask

    // One clock cycle: apply inputs, compare outputs against the model, then advance the model.
    task automatic cycle(input logic rst, input logic fetch, input logic [31:0] addr, input logic hit,
                         input logic flush, input logic ready, input logic rvalid,
                         input logic [31:0] rdata);
        logic [255:0] exp_line;
        bit           was_idle;
        @(posedge clk);
        #1;
        arst         = rst;
        i_fetch_req  = fetch;
        i_instr_addr = addr;
        i_hit        = hit;
        i_flush      = flush;
        i_mem_ready  = ready;
        i_mem_rvalid = rvalid;
        i_mem_rdata  = rdata;
        #3;
        obs_req   = o_mem_req;
        obs_addr  = o_mem_addr;
        obs_we    = o_cache_we;
        obs_inv   = o_invalidate;
        obs_stall = o_stall;
        obs_line  = o_line;
        for (int i = 0; i < 8; i++) exp_line[i*32 +: 32] = m_words[i];
        chk("mem_req",    256'(obs_req),   256'(m_busy && !m_issued));
        chk("mem_addr",   256'(obs_addr),  256'(m_base));
        chk("cache_we",   256'(obs_we),    256'(m_busy && m_nbeats == 8));
        chk("invalidate", 256'(obs_inv),   256'(!m_busy && m_pend));
        chk("stall",      256'(obs_stall), 256'(m_busy || m_pend || (fetch && !hit && addr[1:0] == 2'b00)));
        chk("line",       obs_line,        exp_line);
`ifdef ICACHE_MISS_CNT_EN
        chk("miss_count", 256'(o_miss_count), 256'(m_cnt));
`endif
        if (rst) begin
            model_reset();
        end else begin
            was_idle = !m_busy;
            if (!m_busy) begin
                if (fetch && !hit && addr[1:0] == 2'b00 && !m_pend && !flush) begin
                    m_busy   = 1;
                    m_issued = 0;
                    m_nbeats = 0;
                    m_base   = addr & 32'hFFFF_FFE0;
                    m_cnt    = m_cnt + 32'd1;
                end
            end else if (!m_issued) begin
                if (ready) m_issued = 1;
            end else if (m_nbeats < 8) begin
                if (rvalid) begin
                    m_words[m_nbeats] = rdata;
                    m_nbeats++;
                end
            end else begin
                m_busy = 0;
            end
            if (flush) m_pend = 1;
            else if (was_idle) m_pend = 0;
        end
    endtask

`ifdef ICACHE_MISS_CNT_EN
    task automatic do_refill(input logic [31:0] addr);
        cycle(0, 1, addr, 0, 0, 1, 0, 0);
        cycle(0, 1, addr, 0, 0, 1, 0, 0);
        for (int k = 0; k < 8; k++) cycle(0, 1, addr, 0, 0, 1, 1, 32'h100 + k);
        cycle(0, 1, addr, 0, 0, 1, 0, 0);
        cycle(0, 1, addr, 1, 0, 1, 0, 0);
    endtask
`endif

    initial begin
        arst = 1; i_fetch_req = 0; i_instr_addr = '0; i_hit = 0; i_flush = 0;
        i_mem_ready = 0; i_mem_rvalid = 0; i_mem_rdata = '0;
        model_reset();
        repeat (3) @(posedge clk);

        // Reset state
        cycle(0, 0, 32'h0, 0, 0, 0, 0, 0);
        chk("rst_req",   256'(obs_req),   256'(0));
        chk("rst_stall", 256'(obs_stall), 256'(0));
        chk("rst_line",  obs_line,        256'(0));

        // Basic miss with back-to-back beats
        cycle(0, 1, 32'h0000_1234, 0, 0, 1, 0, 0);
        cycle(0, 1, 32'h0000_1234, 0, 0, 1, 0, 0);
        chk("lat_req1",  256'(obs_req),  256'(1));
        chk("lat_addr1", 256'(obs_addr), 256'(32'h0000_1220));
        for (int k = 0; k < 8; k++) cycle(0, 1, 32'h0000_1234, 0, 0, 1, 1, 32'hA0 + k);
        cycle(0, 1, 32'h0000_1234, 0, 0, 1, 0, 0);
        chk("lat_we10",   256'(obs_we),            256'(1));
        chk("line_low",   256'(obs_line[31:0]),    256'(32'hA0));
        chk("line_high",  256'(obs_line[255:224]), 256'(32'hA7));
        cycle(0, 1, 32'h0000_1234, 1, 0, 1, 0, 0);
        chk("hit11_stall", 256'(obs_stall), 256'(0));
        chk("hit11_we",    256'(obs_we),    256'(0));

        // Memory back-pressure in REQ
        cycle(0, 1, 32'h0000_2004, 0, 0, 0, 0, 0);
        for (int c = 0; c < 3; c++) begin
            cycle(0, 1, 32'h0000_2004, 0, 0, 0, 0, 0);
            chk("bp_req",  256'(obs_req),  256'(1));
            chk("bp_addr", 256'(obs_addr), 256'(32'h0000_2000));
        end
        cycle(0, 1, 32'h0000_2004, 0, 0, 1, 0, 0);
        cycle(0, 1, 32'h0000_2004, 0, 0, 1, 0, 0);
        chk("bp_req_drop", 256'(obs_req), 256'(0));
        for (int k = 0; k < 8; k++) begin
            cycle(0, 1, 32'h0000_2004, 0, 0, 1, 1, 32'hB0 + k);
            chk("bp_no_dup", 256'(obs_req), 256'(0));
        end
        cycle(0, 1, 32'h0000_2004, 0, 0, 1, 0, 0);
        cycle(0, 1, 32'h0000_2004, 1, 0, 1, 0, 0);

        // Flush during beat 4
        cycle(0, 1, 32'h0000_4040, 0, 0, 1, 0, 0);
        cycle(0, 1, 32'h0000_4040, 0, 0, 1, 0, 0);
        for (int k = 0; k < 8; k++) cycle(0, 1, 32'h0000_4040, 0, k == 4, 1, 1, 32'hC0 + k);
        cycle(0, 1, 32'h0000_4040, 0, 0, 1, 0, 0);
        chk("fl_we",    256'(obs_we),  256'(1));
        chk("fl_noinv", 256'(obs_inv), 256'(0));
        cycle(0, 1, 32'h0000_4040, 1, 0, 1, 0, 0);
        chk("fl_inv",   256'(obs_inv), 256'(1));
        chk("fl_nowe",  256'(obs_we),  256'(0));

        // Flush together with a miss in IDLE: invalidate first
        cycle(0, 1, 32'h0000_5000, 0, 1, 1, 0, 0);
        cycle(0, 1, 32'h0000_5000, 0, 0, 1, 0, 0);
        chk("fm_inv", 256'(obs_inv), 256'(1));
        chk("fm_req", 256'(obs_req), 256'(0));
        cycle(0, 1, 32'h0000_5000, 0, 0, 1, 0, 0);
        cycle(0, 1, 32'h0000_5000, 0, 0, 1, 0, 0);
        chk("fm_req_late", 256'(obs_req), 256'(1));
        for (int k = 0; k < 8; k++) cycle(0, 1, 32'h0000_5000, 0, 0, 1, 1, 32'hD0 + k);
        cycle(0, 1, 32'h0000_5000, 0, 0, 1, 0, 0);
        cycle(0, 1, 32'h0000_5000, 1, 0, 1, 0, 0);

        // Misaligned fetch never refills
        for (int c = 0; c < 3; c++) begin
            cycle(0, 1, 32'h0000_1002, 0, 0, 1, 0, 0);
            chk("mis_req",   256'(obs_req),   256'(0));
            chk("mis_stall", 256'(obs_stall), 256'(0));
        end

        // Reset during beat 3
        cycle(0, 1, 32'h0000_3000, 0, 0, 1, 0, 0);
        cycle(0, 1, 32'h0000_3000, 0, 0, 1, 0, 0);
        for (int k = 0; k < 3; k++) cycle(0, 1, 32'h0000_3000, 0, 0, 1, 1, 32'hE0 + k);
        cycle(1, 1, 32'h0000_3000, 0, 0, 1, 1, 32'hE3);
        for (int k = 4; k < 9; k++) begin
            cycle(0, 0, 32'h0000_3000, 0, 0, 1, 1, 32'hE0 + k);
            chk("ar_nowe",  256'(obs_we),    256'(0));
            chk("ar_req",   256'(obs_req),   256'(0));
            chk("ar_stall", 256'(obs_stall), 256'(0));
        end

`ifdef ICACHE_MISS_CNT_EN
        cycle(1, 0, 32'h0, 0, 0, 0, 0, 0);
        do_refill(32'h0000_6000);
        cycle(0, 1, 32'h0000_7000, 1, 0, 1, 0, 0);
        do_refill(32'h0000_6100);
        cycle(0, 1, 32'h0000_7004, 1, 0, 1, 0, 0);
        do_refill(32'h0000_6200);
        chk("cnt_three", 256'(o_miss_count), 256'(3));
`endif

        // Randomized traffic
        for (int c = 0; c < 3000; c++) begin
            logic [31:0] a;
            a = $urandom & 32'h0000_FFFF;
            if ($urandom_range(99, 0) < 80) a[1:0] = 2'b00;
            cycle($urandom_range(199, 0) == 0,
                  $urandom_range(99, 0) < 70,
                  a,
                  $urandom_range(99, 0) < 50,
                  $urandom_range(99, 0) < 3,
                  $urandom_range(99, 0) < 60,
                  $urandom_range(99, 0) < 60,
                  $urandom);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
